// File: rtl/timer_sched.sv
// Round-robin front end that shares one countdown timer among NREQ requesters.
// Latches the winner's duration, loads the timer and returns a Done pulse on expiry.
module timer_sched #(
    parameter int NREQ = 4,
    parameter int TW   = 8
) (
    input  logic               Clk_i,
    input  logic               Rst_ni,
    input  logic [NREQ-1:0]    Req_i,
    input  logic [NREQ*TW-1:0] Time_i,
    output logic [NREQ-1:0]    Grant_o,
    output logic [NREQ-1:0]    Done_o,
    output logic               Busy_o,
    output logic               Trig_o,
    output logic [TW-1:0]      TimeVal_o,
    input  logic               TimeOut_i
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT,
        DONE,
        CLEAR
    } state_t;

    state_t         state_q, state_d;
    logic [IW-1:0]  ptr_q, ptr_d;
    logic [IW-1:0]  owner_q, owner_d;
    logic [TW-1:0]  val_q, val_d;
    logic [IW-1:0]  pick;
    logic [IW:0]    idx;
    logic           found;
    logic [IW-1:0]  owner_inc;
    logic [NREQ-1:0] owner_vec;

    // First requester at or after ptr_q, wrapping modulo NREQ.
    always_comb begin
        pick  = ptr_q;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = {1'b0, ptr_q} + (IW+1)'(i);
            if (idx >= (IW+1)'(NREQ)) begin
                idx = idx - (IW+1)'(NREQ);
            end
            if (!found && Req_i[idx[IW-1:0]]) begin
                found = 1'b1;
                pick  = idx[IW-1:0];
            end
        end
    end

    assign owner_inc = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + IW'(1);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        val_d   = val_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    owner_d = pick;
                    val_d   = Time_i[pick*TW +: TW];
                    state_d = LOAD;
                end
            end
            LOAD: begin
                // A zero duration would never expire, so skip straight to Done.
                state_d = (val_q != '0) ? WAIT : DONE;
            end
            WAIT: begin
                if (!Req_i[owner_q]) begin
                    state_d = CLEAR;
                end else if (TimeOut_i) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                ptr_d   = owner_inc;
                state_d = IDLE;
            end
            CLEAR: begin
                ptr_d   = owner_inc;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk_i or negedge Rst_ni) begin
        if (!Rst_ni) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            val_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            val_q   <= val_d;
        end
    end

    assign owner_vec = NREQ'(1) << owner_q;

    always_comb begin
        Grant_o   = '0;
        Done_o    = '0;
        Trig_o    = 1'b0;
        TimeVal_o = '0;
        Busy_o    = (state_q != IDLE);
        case (state_q)
            LOAD: begin
                Grant_o   = owner_vec;
                Trig_o    = (val_q != '0);
                TimeVal_o = val_q;
            end
            WAIT: Grant_o = owner_vec;
            DONE: begin
                Grant_o = owner_vec;
                Done_o  = owner_vec;
            end
            // Reload with zero so an abandoned countdown cannot fire later.
            CLEAR: Trig_o = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_timer_sched.sv
// Directed bench for timer_sched with a behavioural model of the shared timer.
module tb_timer_sched;

    localparam int NREQ = 4;
    localparam int TW   = 8;

    logic               Clk_i;
    logic               Rst_ni;
    logic [NREQ-1:0]    Req_i;
    logic [NREQ*TW-1:0] Time_i;
    logic [NREQ-1:0]    Grant_o;
    logic [NREQ-1:0]    Done_o;
    logic               Busy_o;
    logic               Trig_o;
    logic [TW-1:0]      TimeVal_o;
    logic               TimeOut_i;

    logic [TW-1:0]      cnt;
    logic               force_to;
    int                 n_chk;
    int                 n_fail;

    timer_sched #(.NREQ(NREQ), .TW(TW)) dut (
        .Clk_i     (Clk_i),
        .Rst_ni    (Rst_ni),
        .Req_i     (Req_i),
        .Time_i    (Time_i),
        .Grant_o   (Grant_o),
        .Done_o    (Done_o),
        .Busy_o    (Busy_o),
        .Trig_o    (Trig_o),
        .TimeVal_o (TimeVal_o),
        .TimeOut_i (TimeOut_i)
    );

    initial begin
        Clk_i = 1'b0;
        forever #5 Clk_i = ~Clk_i;
    end

    // Shared timer: load on Trig_o, expiry pulse while count==1.
    always @(posedge Clk_i or negedge Rst_ni) begin
        if (!Rst_ni)          cnt <= '0;
        else if (Trig_o)      cnt <= TimeVal_o;
        else if (cnt != '0)   cnt <= cnt - 1'b1;
    end
    assign TimeOut_i = (cnt == TW'(1)) | force_to;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge Clk_i);
    endtask

    task automatic set_time(input int k, input int v);
        Time_i[k*TW +: TW] = TW'(v);
    endtask

    task automatic do_reset();
        Rst_ni   = 1'b0;
        Req_i    = '0;
        Time_i   = '0;
        force_to = 1'b0;
        tick();
        tick();
        check("rst_grant", Grant_o, 0);
        check("rst_done", Done_o, 0);
        check("rst_busy", Busy_o, 0);
        check("rst_trig", Trig_o, 0);
        check("rst_timeval", TimeVal_o, 0);
        Rst_ni = 1'b1;
        tick();
    endtask

    // Waits for the next grant (LOAD), then follows it through to the Done pulse.
    task automatic serve(input logic [NREQ-1:0] g, input int t);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (Grant_o == '0 && n < 20);
        check("grant_load", Grant_o, g);
        check("trig_load", Trig_o, t != 0);
        check("timeval_load", TimeVal_o, t);
        check("busy_load", Busy_o, 1);
        for (int i = 0; i < t; i++) begin
            tick();
            check("done_early", Done_o, 0);
            check("grant_wait", Grant_o, g);
            check("trig_wait", Trig_o, 0);
            check("timeval_wait", TimeVal_o, 0);
        end
        tick();
        check("done", Done_o, g);
        check("grant_done", Grant_o, g);
    endtask

    initial begin
        n_chk    = 0;
        n_fail   = 0;
        Rst_ni   = 1'b0;
        Req_i    = '0;
        Time_i   = '0;
        force_to = 1'b0;

        // 1: single requester, duration 5
        do_reset();
        Req_i = 4'b0001;
        set_time(0, 5);
        serve(4'b0001, 5);
        Req_i = '0;
        tick();
        check("t1_done_once", Done_o, 0);
        check("t1_grant_off", Grant_o, 0);
        check("t1_idle", Busy_o, 0);

        // 2: all requesting, round robin 0,1,2,3 then 0
        do_reset();
        Req_i = 4'b1111;
        for (int k = 0; k < NREQ; k++) set_time(k, 3);
        serve(4'b0001, 3);
        serve(4'b0010, 3);
        serve(4'b0100, 3);
        serve(4'b1000, 3);
        serve(4'b0001, 3);
        Req_i = '0;
        tick();
        tick();
        check("t2_idle", Busy_o, 0);

        // 3: zero duration skips the timer
        do_reset();
        Req_i = 4'b0100;
        set_time(2, 0);
        serve(4'b0100, 0);
        Req_i = '0;
        tick();
        check("t3_done_once", Done_o, 0);

        // 4: abandon in WAIT, then requester 1 is served
        do_reset();
        Req_i = 4'b0011;
        set_time(0, 20);
        set_time(1, 2);
        tick();
        check("t4_grant0", Grant_o, 4'b0001);
        check("t4_timeval0", TimeVal_o, 20);
        repeat (3) tick();
        check("t4_wait_grant", Grant_o, 4'b0001);
        Req_i = 4'b0010;
        tick();
        check("t4_clr_trig", Trig_o, 1);
        check("t4_clr_timeval", TimeVal_o, 0);
        check("t4_clr_grant", Grant_o, 0);
        check("t4_clr_done", Done_o, 0);
        check("t4_clr_busy", Busy_o, 1);
        serve(4'b0010, 2);
        Req_i = '0;
        tick();

        // 5: asynchronous reset in WAIT
        do_reset();
        Req_i = 4'b0001;
        set_time(0, 10);
        repeat (3) tick();
        check("t5_in_wait", Grant_o, 4'b0001);
        #2 Rst_ni = 1'b0;
        #1;
        check("t5_rst_grant", Grant_o, 0);
        check("t5_rst_done", Done_o, 0);
        check("t5_rst_busy", Busy_o, 0);
        check("t5_rst_trig", Trig_o, 0);
        tick();
        Req_i = 4'b1001;
        set_time(0, 2);
        set_time(3, 2);
        Rst_ni = 1'b1;
        serve(4'b0001, 2);
        Req_i = 4'b1000;
        serve(4'b1000, 2);
        Req_i = '0;
        tick();

        // 6: expiry pulses outside WAIT are ignored
        do_reset();
        force_to = 1'b1;
        repeat (3) begin
            tick();
            check("t6_idle_busy", Busy_o, 0);
            check("t6_idle_done", Done_o, 0);
        end
        force_to = 1'b0;
        Req_i = 4'b0001;
        set_time(0, 3);
        tick();
        check("t6_load_grant", Grant_o, 4'b0001);
        check("t6_load_timeval", TimeVal_o, 3);
        force_to = 1'b1;
        tick();
        force_to = 1'b0;
        check("t6_after_load_done", Done_o, 0);
        check("t6_after_load_grant", Grant_o, 4'b0001);
        repeat (2) begin
            tick();
            check("t6_wait_done", Done_o, 0);
        end
        tick();
        check("t6_done", Done_o, 4'b0001);
        Req_i = '0;
        tick();
        check("t6_idle_end", Busy_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
